// File: rtl/conv_window_feeder.sv
// conv_window_feeder: holds one MAP_H x MAP_W map and streams every K x K
// window as N_CELL-wide chunks, in raster order or in 2x2 pool-quad order.
// Optional feature macro: CONV_WINDOW_FEEDER_HALF_SCALE_EN stores wr_data>>1
// so every pixel is non-negative in the core's signed arithmetic.
module conv_window_feeder #(
  parameter int CELL_BIT = 8,
  parameter int N_CELL   = 9,
  parameter int MAP_W    = 28,
  parameter int MAP_H    = 28,
  parameter int K        = 4,
  parameter int ADDR_W   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [CELL_BIT-1:0]        wr_data,
  input  logic                       start,
  input  logic                       en_mp,
  input  logic                       out_ready,
  output logic [CELL_BIT*N_CELL-1:0] out_data,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int N_PIX = MAP_W * MAP_H;
  localparam int AW    = $clog2(N_PIX);
  localparam int KK    = K * K;
  localparam int NCH   = (KK + N_CELL - 1) / N_CELL;
  localparam int OH    = MAP_H - K + 1;
  localparam int OW    = MAP_W - K + 1;
  localparam int PH    = OH / 2;
  localparam int PW    = OW / 2;
  localparam int DW    = CELL_BIT * N_CELL;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic [CELL_BIT-1:0] mem [N_PIX];
  logic [CELL_BIT-1:0] pix_in;

  // Beat position: chunk, outer index (row / pool row), inner index
  // (column / pool column) and quad member; mode is the latched en_mp.
  int   ch, a, b, q;
  int   ch_n, a_n, b_n, q_n;
  logic mode, mode_n;

  logic [DW-1:0] data_n;
  logic          valid_n, first_n, last_n, busy_n, done_n;
  logic          accept, final_beat, load;
  int            r0, c0, e;

`ifdef CONV_WINDOW_FEEDER_HALF_SCALE_EN
  assign pix_in = {1'b0, wr_data[CELL_BIT-1:1]};
`else
  assign pix_in = wr_data;
`endif

  // Map storage: written only while idle, out-of-range addresses dropped.
  // NOTE: the map array has no reset on purpose; a pass must be replayable
  // after reset, and a reset on a register file only costs logic.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && int'(wr_addr) < N_PIX)
      mem[AW'(wr_addr)] <= pix_in;
  end

  // Next-state, beat sequencing and next-output computation.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_n = state;
    mode_n  = mode;
    ch_n    = ch;
    a_n     = a;
    b_n     = b;
    q_n     = q;
    data_n  = out_data;
    valid_n = out_valid;
    first_n = out_first;
    last_n  = out_last;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    r0      = 0;
    c0      = 0;
    e       = 0;

    accept     = out_valid && out_ready;
    final_beat = (ch == NCH - 1) &&
                 (mode ? (a == PH - 1 && b == PW - 1 && q == 3)
                       : (a == OH - 1 && b == OW - 1));

    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          mode_n  = en_mp;
          ch_n    = 0;
          a_n     = 0;
          b_n     = 0;
          q_n     = 0;
          busy_n  = 1'b1;
          valid_n = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (final_beat) begin
            state_n = DONE;
            valid_n = 1'b0;
            first_n = 1'b0;
            last_n  = 1'b0;
            data_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            load = 1'b1;
            if (ch < NCH - 1) begin
              ch_n = ch + 1;
            end else begin
              ch_n = 0;
              if (mode && q < 3) begin
                q_n = q + 1;
              end else begin
                q_n = 0;
                if (b < (mode ? PW : OW) - 1) begin
                  b_n = b + 1;
                end else begin
                  b_n = 0;
                  a_n = a + 1;
                end
              end
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Present the chunk selected by the advanced position.
    if (load) begin
      r0      = mode_n ? 2 * a_n + q_n / 2 : a_n;
      c0      = mode_n ? 2 * b_n + q_n % 2 : b_n;
      first_n = (ch_n == 0);
      last_n  = (ch_n == NCH - 1);
      data_n  = '0;
      for (int s = 0; s < N_CELL; s++) begin
        e = ch_n * N_CELL + s;
        if (e < KK)
          data_n[DW-1-s*CELL_BIT -: CELL_BIT] =
            mem[AW'((r0 + e / K) * MAP_W + c0 + e % K)];
      end
    end
  end

  // Registered state, position and outputs with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode      <= 1'b0;
      ch        <= 0;
      a         <= 0;
      b         <= 0;
      q         <= 0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      ch        <= ch_n;
      a         <= a_n;
      b         <= b_n;
      q         <= q_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_first <= first_n;
      out_last  <= last_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: directed passes plus random
// maps and random backpressure, compared against a window-list model.
module tb_conv_window_feeder;

  localparam int CB  = 8;
  localparam int NC  = 9;
  localparam int MW  = 28;
  localparam int MH  = 28;
  localparam int K   = 4;
  localparam int AW  = 10;
  localparam int DW  = CB * NC;
  localparam int NCH = (K * K + NC - 1) / NC;
  localparam int OH  = MH - K + 1;
  localparam int OW  = MW - K + 1;

`ifdef CONV_WINDOW_FEEDER_HALF_SCALE_EN
  localparam logic [DW-1:0] RB0 = 72'h000001010808090910;
  localparam logic [DW-1:0] RB1 = 72'h101111181819190000;
  localparam logic [DW-1:0] PB2 = 72'h00010102080909_0A10;
  localparam logic [DW-1:0] PB8 = 72'h0101020209090A0A11;
  localparam logic [CB-1:0] FF_SLOT = 8'h7F;
`else
  localparam logic [DW-1:0] RB0 = 72'h000102031011121320;
  localparam logic [DW-1:0] RB1 = 72'h212223303132330000;
  localparam logic [DW-1:0] PB2 = 72'h010203041112131421;
  localparam logic [DW-1:0] PB8 = 72'h020304051213141522;
  localparam logic [CB-1:0] FF_SLOT = 8'hFF;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CB-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          en_mp = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid, out_first, out_last, busy, done;

  always #5 clk = ~clk;

  conv_window_feeder #(.CELL_BIT(CB), .N_CELL(NC), .MAP_W(MW), .MAP_H(MH),
                       .K(K), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .en_mp(en_mp), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } beat_t;

  logic [CB-1:0] mdl [MH*MW];
  beat_t         expq [$];
  logic [DW-1:0] got [16];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one map write as the block stores it.
  task automatic model_write(input int addr, input logic [CB-1:0] v);
    if (addr < MH * MW) begin
`ifdef CONV_WINDOW_FEEDER_HALF_SCALE_EN
      mdl[addr] = v >> 1;
`else
      mdl[addr] = v;
`endif
    end
  endtask

  task automatic write_px(input int addr, input logic [CB-1:0] v);
    wr_en = 1'b1;
    wr_addr = AW'(addr);
    wr_data = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(addr, v);
  endtask

  // Append all chunks of the window whose top-left corner is (r0,c0).
  function automatic void push_window(input int r0, input int c0);
    beat_t bt;
    int e;
    for (int c = 0; c < NCH; c++) begin
      bt.d = '0;
      for (int s = 0; s < NC; s++) begin
        e = c * NC + s;
        if (e < K * K)
          bt.d[DW-1-s*CB -: CB] = mdl[(r0 + e / K) * MW + c0 + e % K];
      end
      bt.f = (c == 0);
      bt.l = (c == NCH - 1);
      expq.push_back(bt);
    end
  endfunction

  // Expected beat list from the window-origin enumeration rules.
  function automatic void build(input bit mode);
    expq.delete();
    if (!mode) begin
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          push_window(r, c);
    end else begin
      for (int pr = 0; pr < OH / 2; pr++)
        for (int pc = 0; pc < OW / 2; pc++)
          for (int qq = 0; qq < 4; qq++)
            push_window(2 * pr + qq / 2, 2 * pc + qq % 2);
    end
  endfunction

  // One pass: start, consume beats (optionally stalled), compare each beat,
  // optionally inject writes/start mid-pass or abort with reset at beat rst_at.
  task automatic run_pass(input bit mode, input bit bp, input int rst_at,
                          input bit inject, output int n_beats);
    int idx = 0;
    int cyc = 0;
    logic [DW-1:0] pd;
    logic pv, pr, pf, pl;
    build(mode);
    en_mp = mode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    en_mp = 1'b0;
    check("busy_after_start", DW'(busy), 1);
    check("valid_after_start", DW'(out_valid), 1);
    while (idx < expq.size() && cyc < 20000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && cyc == 50) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hAA; start = 1'b1; en_mp = ~mode;
      end else begin
        wr_en = 1'b0; start = 1'b0; en_mp = 1'b0;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pf = out_first; pl = out_last;
      if (pv && pr) begin
        check("beat_data", pd, expq[idx].d);
        check("beat_first", DW'(pf), DW'(expq[idx].f));
        check("beat_last", DW'(pl), DW'(expq[idx].l));
        if (idx < 16) got[idx] = pd;
        idx++;
      end
      check("no_early_done", DW'(done), 0);
      @(posedge clk); #1;
      cyc++;
      if (pv && !pr) begin
        check("stall_data", out_data, pd);
        check("stall_valid", DW'(out_valid), 1);
        check("stall_first", DW'(out_first), DW'(pf));
        check("stall_last", DW'(out_last), DW'(pl));
      end
      if (rst_at > 0 && idx == rst_at) begin
        wr_en = 1'b0; start = 1'b0; en_mp = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_valid", DW'(out_valid), 0);
        check("rst_busy", DW'(busy), 0);
        check("rst_done", DW'(done), 0);
        @(posedge clk); #1;
        check("rst_no_done", DW'(done), 0);
        n_beats = idx;
        return;
      end
    end
    wr_en = 1'b0; start = 1'b0; en_mp = 1'b0; out_ready = 1'b1;
    n_beats = idx;
    check("pass_complete", DW'(idx), DW'(expq.size()));
    check("end_done", DW'(done), 1);
    check("end_valid", DW'(out_valid), 0);
    check("end_busy", DW'(busy), 0);
    @(posedge clk); #1;
    check("done_pulse_len", DW'(done), 0);
    check("idle_busy", DW'(busy), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_valid", DW'(out_valid), 0);
    check("reset_first", DW'(out_first), 0);
    check("reset_last", DW'(out_last), 0);
    check("reset_data", out_data, 0);
    check("reset_busy", DW'(busy), 0);
    check("reset_done", DW'(done), 0);

    // Gradient map, plus ignored out-of-range writes.
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++)
        write_px(r * MW + c, 8'((r * 16 + c) & 8'hFF));
    write_px(MH * MW, 8'h5A);
    write_px(1000, 8'h5A);

    // Raster pass.
    run_pass(1'b0, 1'b0, 0, 1'b0, n);
    check("raster_total", DW'(n), 1250);
    check("raster_beat0", got[0], RB0);
    check("raster_beat1", got[1], RB1);

    // Pool pass.
    run_pass(1'b1, 1'b0, 0, 1'b0, n);
    check("pool_total", DW'(n), 1152);
    check("pool_beat0", got[0], RB0);
    check("pool_beat2", got[2], PB2);
    check("pool_beat8", got[8], PB8);

    // Backpressure on the raster stream.
    run_pass(1'b0, 1'b1, 0, 1'b0, n);
    check("bp_total", DW'(n), 1250);

    // Reset after 100 accepted beats, then replay with no reload.
    run_pass(1'b0, 1'b0, 100, 1'b0, n);
    check("abort_beats", DW'(n), 100);
    run_pass(1'b0, 1'b0, 0, 1'b0, n);
    check("replay_beat0", got[0], RB0);

    // Writes and start during RUN are ignored.
    run_pass(1'b0, 1'b0, 0, 1'b1, n);
    check("inject_total", DW'(n), 1250);
    run_pass(1'b0, 1'b0, 0, 1'b0, n);
    check("inject_map00", DW'(got[0][DW-1 -: CB]), 0);

    // Write 0xFF at address 0: stored value depends on the scale option.
    write_px(0, 8'hFF);
    run_pass(1'b0, 1'b0, 0, 1'b0, n);
    check("scale_slot0", DW'(got[0][DW-1 -: CB]), DW'(FF_SLOT));

    // Random maps with random backpressure in both orders.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < MH * MW; i++)
        write_px(i, 8'($urandom));
      run_pass(1'(t), 1'b1, 0, 1'b0, n);
      check("rand_total", DW'(n), t == 0 ? 1250 : 1152);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
